// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory-port arbiter: state encodings
// and default bus widths / watchdog limit.
package mem_port_arbiter_pkg;

    localparam int MEM_ARB_ADDR_W         = 32;
    localparam int MEM_ARB_DATA_W         = 32;
    localparam int MEM_ARB_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        MEM_ARB_IDLE   = 2'd0,
        MEM_ARB_BUSY_D = 2'd1,
        MEM_ARB_BUSY_I = 2'd2
    } mem_arb_state_e;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog for the memory-port arbiter. The counter restarts on
// every grant, advances on each busy cycle without an ack, and raises expire_o
// in the cycle where it would reach LIMIT. The timeout flag is sticky until reset.
module mem_arb_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic count_i,
    output logic expire_o,
    output logic timeout_o
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    assign expire_o  = count_i && (cnt_q == LAST);
    assign timeout_o = timeout_q;

    // Busy-cycle counter and sticky timeout flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (clear_i) begin
                cnt_q <= '0;
            end else if (count_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (expire_o) begin
                timeout_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Unified memory-port arbiter: one memory port shared by instruction fetch and
// data access, data having fixed priority. Each access is held until mem_ack_i.
// Optional busy watchdog: define MEM_ARB_TIMEOUT_EN to build it in; otherwise
// timeout_o is tied low and a busy access waits indefinitely.
//
// state          | meaning
// MEM_ARB_IDLE   | port free; grant data first, then an unflushed fetch
// MEM_ARB_BUSY_D | data access on the port, waiting for mem_ack_i
// MEM_ARB_BUSY_I | fetch on the port, waiting for mem_ack_i (may be marked dropped)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W         = MEM_ARB_ADDR_W,
    parameter int DATA_W         = MEM_ARB_DATA_W,
    parameter int TIMEOUT_CYCLES = MEM_ARB_TIMEOUT_CYCLES
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_done_o,
    output logic              if_stall_o,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_done_o,
    output logic              d_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              timeout_o
);

    mem_arb_state_e    state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic              drop_q, drop_d;

    logic              d_pending;
    logic              if_pending;
    logic              wd_expire;

    // A requester whose done pulses this cycle is advancing at the coming edge,
    // so its still-visible request must not be granted a second time.
    assign d_pending  = (d_read_i | d_write_i) & ~d_done_q;
    assign if_pending = if_req_i & ~if_done_q;

`ifdef MEM_ARB_TIMEOUT_EN
    logic wd_clear;
    logic wd_count;

    assign wd_clear = (state_q == MEM_ARB_IDLE) && (state_d != MEM_ARB_IDLE);
    assign wd_count = (state_q != MEM_ARB_IDLE) && !mem_ack_i;

    mem_arb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clock_i),
        .rst_i     (reset_i),
        .clear_i   (wd_clear),
        .count_i   (wd_count),
        .expire_o  (wd_expire),
        .timeout_o (timeout_o)
    );
`else
    // Limit only matters when the watchdog is built in.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign wd_expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Next-state, grant registration and completion capture.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        drop_d      = drop_q;

        case (state_q)
            MEM_ARB_IDLE: begin
                if (d_pending) begin
                    state_d     = MEM_ARB_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_write_i;
                    mem_addr_d  = d_addr_i;
                    mem_wdata_d = d_wdata_i;
                end else if (if_pending && !if_flush_i) begin
                    state_d    = MEM_ARB_BUSY_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr_i;
                    drop_d     = 1'b0;
                end
            end
            MEM_ARB_BUSY_D: begin
                if (mem_ack_i) begin
                    state_d   = MEM_ARB_IDLE;
                    mem_req_d = 1'b0;
                    d_done_d  = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata_i;
                    end
                end else if (wd_expire) begin
                    state_d   = MEM_ARB_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            MEM_ARB_BUSY_I: begin
                if (if_flush_i) begin
                    drop_d = 1'b1;
                end
                if (mem_ack_i) begin
                    state_d   = MEM_ARB_IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    if (!drop_q && !if_flush_i) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata_i;
                    end
                end else if (wd_expire) begin
                    state_d   = MEM_ARB_IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                end
            end
            default: begin
                state_d   = MEM_ARB_IDLE;
                mem_req_d = 1'b0;
                drop_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= MEM_ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            drop_q      <= drop_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign if_done_o   = if_done_q;
    assign d_done_o    = d_done_q;

    // Stalls follow the requests directly; held low during reset so every
    // output reads zero while the arbiter is being reset.
    assign if_stall_o = if_req_i & ~if_done_q & ~reset_i;
    assign d_stall_o  = (d_read_i | d_write_i) & ~d_done_q & ~reset_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (default build, watchdog not compiled in).
module tb_mem_port_arbiter;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        if_req_i, if_flush_i, d_read_i, d_write_i, mem_ack_i;
    logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
    logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
    logic        if_done_o, if_stall_o, d_done_o, d_stall_o, mem_req_o, mem_we_o, timeout_o;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;

    always #5 clock_i = ~clock_i;

    mem_port_arbiter dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_rdata_o  (if_rdata_o),
        .if_done_o   (if_done_o),
        .if_stall_o  (if_stall_o),
        .d_read_i    (d_read_i),
        .d_write_i   (d_write_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_rdata_o   (d_rdata_o),
        .d_done_o    (d_done_o),
        .d_stall_o   (d_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .timeout_o   (timeout_o)
    );

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s: observed 0x%08h expected 0x%08h", tag, what, obs, exp);
        end
    endtask

    // Waits (bounded) for mem_req; a grant is expected exactly one cycle later.
    task automatic wait_req(input string tag);
        int waited;
        waited = 0;
        do begin
            @(negedge clock_i);
            waited++;
        end while (mem_req_o !== 1'b1 && waited < 8);
        chk(tag, "grant_latency", waited, 1);
    endtask

    // One pipeline step: optional data access (dr/dw) and optional fetch (fr).
    // Reference behaviour: data is served first, a write never changes d_rdata,
    // a flushed fetch yields no done and is re-issued at the redirect address.
    task automatic transact(input string tag, input logic dr, input logic dw, input logic fr,
                            input logic [31:0] faddr, input logic [31:0] daddr, input logic [31:0] wdata,
                            input int lat_d, input int lat_i, input logic flush,
                            input logic [31:0] rd_d, input logic [31:0] rd_i);
        logic [31:0] cur_faddr;
        d_read_i  = dr;
        d_write_i = dw;
        d_addr_i  = daddr;
        d_wdata_i = wdata;
        if_req_i  = fr;
        if_addr_i = faddr;
        cur_faddr = faddr;

        if (dr | dw) begin
            wait_req(tag);
            chk(tag, "d_mem_addr", mem_addr_o, daddr);
            chk(tag, "d_mem_we", {31'd0, mem_we_o}, {31'd0, dw});
            if (dw) chk(tag, "d_mem_wdata", mem_wdata_o, wdata);
            chk(tag, "d_stall_busy", {31'd0, d_stall_o}, 32'd1);
            chk(tag, "if_stall_wait", {31'd0, if_stall_o}, {31'd0, fr});
            repeat (lat_d) @(negedge clock_i);
            chk(tag, "d_addr_stable", mem_addr_o, daddr);
            mem_ack_i   = 1'b1;
            mem_rdata_i = rd_d;
            @(negedge clock_i);
            mem_ack_i = 1'b0;
            if (!dw) exp_d_rdata = rd_d;
            chk(tag, "d_done", {31'd0, d_done_o}, 32'd1);
            chk(tag, "d_rdata", d_rdata_o, exp_d_rdata);
            chk(tag, "d_req_drop", {31'd0, mem_req_o}, 32'd0);
            chk(tag, "d_stall_done", {31'd0, d_stall_o}, 32'd0);
            chk(tag, "if_done_quiet", {31'd0, if_done_o}, 32'd0);
            @(posedge clock_i);
            #1;
            d_read_i  = 1'b0;
            d_write_i = 1'b0;
        end

        if (fr) begin
            for (int pass = 0; pass < (flush ? 2 : 1); pass++) begin
                logic fl;
                fl = flush && (pass == 0);
                wait_req(tag);
                chk(tag, "i_mem_addr", mem_addr_o, cur_faddr);
                chk(tag, "i_mem_we", {31'd0, mem_we_o}, 32'd0);
                chk(tag, "if_stall_busy", {31'd0, if_stall_o}, 32'd1);
                if_flush_i = fl;
                for (int k = 0; k < lat_i; k++) begin
                    @(negedge clock_i);
                    if_flush_i = 1'b0;
                end
                mem_ack_i   = 1'b1;
                mem_rdata_i = fl ? (rd_i ^ 32'hFFFF_0000) : rd_i;
                @(negedge clock_i);
                mem_ack_i  = 1'b0;
                if_flush_i = 1'b0;
                if (!fl) exp_if_rdata = rd_i;
                chk(tag, "if_done", {31'd0, if_done_o}, {31'd0, !fl});
                chk(tag, "if_rdata", if_rdata_o, exp_if_rdata);
                chk(tag, "i_req_drop", {31'd0, mem_req_o}, 32'd0);
                chk(tag, "if_stall_done", {31'd0, if_stall_o}, {31'd0, fl});
                chk(tag, "d_done_quiet", {31'd0, d_done_o}, 32'd0);
                if (fl) begin
                    cur_faddr = faddr + 32'd4;
                    if_addr_i = cur_faddr;
                end
            end
            @(posedge clock_i);
            #1;
            if_req_i = 1'b0;
        end

        @(negedge clock_i);
        chk(tag, "no_regrant", {31'd0, mem_req_o}, 32'd0);
        chk(tag, "done_single", {30'd0, if_done_o, d_done_o}, 32'd0);
        chk(tag, "timeout", {31'd0, timeout_o}, 32'd0);
    endtask

    initial begin
        reset_i     = 1'b1;
        if_req_i    = 1'b0;
        if_flush_i  = 1'b0;
        d_read_i    = 1'b0;
        d_write_i   = 1'b0;
        mem_ack_i   = 1'b0;
        if_addr_i   = '0;
        d_addr_i    = '0;
        d_wdata_i   = '0;
        mem_rdata_i = '0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;

        repeat (2) @(negedge clock_i);
        chk("reset", "mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("reset", "outs", {25'd0, mem_we_o, if_done_o, d_done_o, if_stall_o, d_stall_o, timeout_o, 1'b0}, 32'd0);
        chk("reset", "if_rdata", if_rdata_o, 32'd0);
        chk("reset", "d_rdata", d_rdata_o, 32'd0);
        chk("reset", "mem_addr", mem_addr_o, 32'd0);
        reset_i = 1'b0;
        @(negedge clock_i);

        // Fetch at 0x40, ack in the third cycle after grant.
        transact("fetch40", 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 0, 2, 1'b0, 32'h0, 32'h2002000A);
        // Store: data word goes out, d_rdata untouched.
        transact("store", 1'b0, 1'b1, 1'b0, 32'h0, 32'h8, 32'hDEADBEEF, 1, 0, 1'b0, 32'h5555_AAAA, 32'h0);
        // Load and fetch together: data first, fetch granted straight after.
        transact("ld_if", 1'b1, 1'b0, 1'b1, 32'h44, 32'h100, 32'h0, 0, 1, 1'b0, 32'hA5A5_0100, 32'h0BAD_F00D);
        // Flush while the fetch is busy; result dropped, redirected fetch reissued.
        transact("flush", 1'b0, 1'b0, 1'b1, 32'h48, 32'h0, 32'h0, 0, 2, 1'b1, 32'h0, 32'h0000_1234);
        // Read and write together behave as a write.
        transact("rdwr", 1'b1, 1'b1, 1'b0, 32'h0, 32'h20, 32'h1357_9BDF, 2, 0, 1'b0, 32'h7777_7777, 32'h0);

        // Flush in IDLE suppresses the fetch grant for that cycle only.
        if_req_i   = 1'b1;
        if_addr_i  = 32'h80;
        if_flush_i = 1'b1;
        @(negedge clock_i);
        chk("idle_flush", "mem_req", {31'd0, mem_req_o}, 32'd0);
        if_flush_i = 1'b0;
        transact("idle_flush", 1'b0, 1'b0, 1'b1, 32'h80, 32'h0, 32'h0, 0, 0, 1'b0, 32'h0, 32'hC0DE_0080);

        // Stray ack while idle is ignored.
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFEED_FACE;
        @(negedge clock_i);
        mem_ack_i = 1'b0;
        @(negedge clock_i);
        chk("idle_ack", "dones", {30'd0, if_done_o, d_done_o}, 32'd0);
        chk("idle_ack", "if_rdata", if_rdata_o, exp_if_rdata);
        chk("idle_ack", "d_rdata", d_rdata_o, exp_d_rdata);
        chk("idle_ack", "mem_req", {31'd0, mem_req_o}, 32'd0);

        // Randomised pipeline steps.
        for (int it = 0; it < 40; it++) begin
            int kind;
            logic fr;
            kind = $urandom_range(0, 3);
            fr   = (kind == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            transact("rand", kind[0], kind[1], fr,
                     $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom,
                     $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                     $urandom, $urandom);
        end

        // Async reset in the middle of a data access.
        d_read_i = 1'b1;
        d_addr_i = 32'h200;
        wait_req("rst_mid");
        chk("rst_mid", "mem_addr", mem_addr_o, 32'h200);
        #2 reset_i = 1'b1;
        #1;
        chk("rst_mid", "mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_mid", "outs", {25'd0, mem_we_o, if_done_o, d_done_o, if_stall_o, d_stall_o, timeout_o, 1'b0}, 32'd0);
        chk("rst_mid", "mem_addr0", mem_addr_o, 32'd0);
        chk("rst_mid", "if_rdata", if_rdata_o, 32'd0);
        chk("rst_mid", "d_rdata", d_rdata_o, 32'd0);
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        @(negedge clock_i);
        reset_i = 1'b0;
        transact("rst_fresh", 1'b1, 1'b0, 1'b0, 32'h0, 32'h200, 32'h0, 1, 0, 1'b0, 32'h0000_0200, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
